// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding uart_tx with a one-cycle issue strobe
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            WR_D,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVF,
  input  logic                  OVF_CLR,
  output logic [7:0]            TX_D,
  output logic                  TX_EN,
  input  logic                  TX_RDY
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_C   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  tx_en_q, tx_en_d;
  logic [7:0]            tx_d_q, tx_d_d;

  logic full_w;
  logic empty_w;
  logic push_w;
  logic drop_w;
  logic pop_w;

  always_comb begin
    full_w  = (count_q == DEPTH_C);
    empty_w = (count_q == '0);
    push_w  = WR_EN && !full_w;
    drop_w  = WR_EN && full_w;
    // Skipping the cycle after a strobe covers uart_tx latching before RDY falls.
    pop_w   = !tx_en_q && TX_RDY && !empty_w;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    tx_en_d  = 1'b0;
    tx_d_d   = tx_d_q;

    if (push_w) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      tx_en_d  = 1'b1;
      tx_d_d   = mem_q[rd_ptr_q];
    end

    case ({push_w, pop_w})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    // A dropped write outranks a clear in the same cycle.
    if (drop_w) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      tx_en_q  <= 1'b0;
      tx_d_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      tx_en_q  <= tx_en_d;
      tx_d_q   <= tx_d_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_w && !RST) begin
      mem_q[wr_ptr_q] <= WR_D;
    end
  end

  assign FULL  = full_w;
  assign EMPTY = empty_w;
  assign COUNT = count_q;
  assign OVF   = ovf_q;
  assign TX_EN = tx_en_q;
  assign TX_D  = tx_d_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       CLK;
  logic       RST;
  logic [7:0] WR_D;
  logic       WR_EN;
  logic       FULL;
  logic       EMPTY;
  logic [4:0] COUNT;
  logic       OVF;
  logic       OVF_CLR;
  logic [7:0] TX_D;
  logic       TX_EN;
  logic       TX_RDY;

  int n_cmp;
  int n_bad;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .WR_D    (WR_D),
    .WR_EN   (WR_EN),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
    .COUNT   (COUNT),
    .OVF     (OVF),
    .OVF_CLR (OVF_CLR),
    .TX_D    (TX_D),
    .TX_EN   (TX_EN),
    .TX_RDY  (TX_RDY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0] exp_q [3];
    int strobes;

    n_cmp   = 0;
    n_bad   = 0;
    RST     = 1'b1;
    WR_D    = 8'h00;
    WR_EN   = 1'b0;
    OVF_CLR = 1'b0;
    TX_RDY  = 1'b1;
    tick();
    tick();

    check_eq("rst_empty", 32'(EMPTY), 32'd1);
    check_eq("rst_full",  32'(FULL),  32'd0);
    check_eq("rst_count", 32'(COUNT), 32'd0);
    check_eq("rst_ovf",   32'(OVF),   32'd0);
    check_eq("rst_tx_en", 32'(TX_EN), 32'd0);
    check_eq("rst_tx_d",  32'(TX_D),  32'h00);

    RST = 1'b0;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (TX_EN) strobes++;
    end
    check_eq("idle_strobes", 32'(strobes), 32'd0);
    check_eq("idle_empty",   32'(EMPTY),   32'd1);

    // Single byte: push at edge k, strobe visible after edge k+1, gone after k+2.
    WR_D  = 8'h41;
    WR_EN = 1'b1;
    tick();
    WR_EN = 1'b0;
    check_eq("one_count_k",  32'(COUNT), 32'd1);
    check_eq("one_tx_en_k",  32'(TX_EN), 32'd0);
    tick();
    check_eq("one_tx_en_k1", 32'(TX_EN), 32'd1);
    check_eq("one_tx_d",     32'(TX_D),  32'h41);
    check_eq("one_count_k1", 32'(COUNT), 32'd0);
    tick();
    check_eq("one_tx_en_k2", 32'(TX_EN), 32'd0);
    check_eq("one_tx_d_hold", 32'(TX_D), 32'h41);

    // Fill with the transmitter busy; pointers start at 1 so storage wraps.
    TX_RDY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      WR_D  = 8'(i);
      WR_EN = 1'b1;
      tick();
    end
    check_eq("fill_count", 32'(COUNT), 32'd16);
    check_eq("fill_full",  32'(FULL),  32'd1);
    check_eq("fill_ovf",   32'(OVF),   32'd0);
    WR_D = 8'hFF;
    tick();
    check_eq("drop_ovf",   32'(OVF),   32'd1);
    check_eq("drop_count", 32'(COUNT), 32'd16);

    WR_D    = 8'hEE;
    OVF_CLR = 1'b1;
    tick();
    check_eq("ovf_set_wins", 32'(OVF), 32'd1);
    WR_EN = 1'b0;
    tick();
    OVF_CLR = 1'b0;
    check_eq("ovf_cleared", 32'(OVF), 32'd0);
    check_eq("ovf_count",   32'(COUNT), 32'd16);

    for (int i = 0; i < 16; i++) begin
      TX_RDY = 1'b1;
      tick();
      check_eq($sformatf("drain_en_%0d", i), 32'(TX_EN), 32'd1);
      check_eq($sformatf("drain_d_%0d", i),  32'(TX_D),  32'(i));
      TX_RDY = 1'b0;
      tick();
      check_eq($sformatf("drain_off_%0d", i), 32'(TX_EN), 32'd0);
      for (int j = 0; j < 4; j++) tick();
    end
    check_eq("drain_count", 32'(COUNT), 32'd0);
    check_eq("drain_empty", 32'(EMPTY), 32'd1);

    // COUNT=3 with simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      WR_D  = 8'h11 * 8'(i + 1);
      WR_EN = 1'b1;
      tick();
    end
    check_eq("three_count", 32'(COUNT), 32'd3);
    WR_D   = 8'hA5;
    TX_RDY = 1'b1;
    tick();
    WR_EN = 1'b0;
    check_eq("pp_count", 32'(COUNT), 32'd3);
    check_eq("pp_tx_en", 32'(TX_EN), 32'd1);
    check_eq("pp_tx_d",  32'(TX_D),  32'h11);
    exp_q[0] = 8'h22;
    exp_q[1] = 8'h33;
    exp_q[2] = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("pp_gap_%0d", i), 32'(TX_EN), 32'd0);
      tick();
      check_eq($sformatf("pp_en_%0d", i), 32'(TX_EN), 32'd1);
      check_eq($sformatf("pp_d_%0d", i),  32'(TX_D),  32'(exp_q[i]));
      check_eq($sformatf("pp_cnt_%0d", i), 32'(COUNT), 32'(2 - i));
    end
    tick();
    check_eq("pp_idle", 32'(TX_EN), 32'd0);

    // Push and pop together while full: push dropped, count falls to DEPTH-1.
    TX_RDY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      WR_D  = 8'h80 + 8'(i);
      WR_EN = 1'b1;
      tick();
    end
    WR_D   = 8'h7E;
    TX_RDY = 1'b1;
    tick();
    WR_EN  = 1'b0;
    TX_RDY = 1'b0;
    check_eq("fpp_count", 32'(COUNT), 32'd15);
    check_eq("fpp_ovf",   32'(OVF),   32'd1);
    check_eq("fpp_tx_d",  32'(TX_D),  32'h80);

    // Reset mid-operation discards everything.
    TX_RDY = 1'b1;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_eq("mrst_count", 32'(COUNT), 32'd0);
    check_eq("mrst_tx_en", 32'(TX_EN), 32'd0);
    check_eq("mrst_ovf",   32'(OVF),   32'd0);
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (TX_EN) strobes++;
    end
    check_eq("mrst_strobes", 32'(strobes), 32'd0);
    check_eq("mrst_empty",   32'(EMPTY),   32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
